// File: rtl/drone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drone_pkg
// Description : Shared link-state type, default constants and the saturating
//               absolute-value helper for the drone sensor monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package drone_pkg;

    typedef enum logic [1:0] {
        LINK_DOWN = 2'd0,
        LINK_ACQ  = 2'd1,
        LINK_UP   = 2'd2
    } link_state_t;

    localparam logic [15:0] C_GYRO_THRESH  = 16'd200;
    localparam int          C_STABLE_CNT   = 8;
    localparam int          C_LINK_ACQ     = 3;
    localparam int          C_LINK_TIMEOUT = 1000;

    // abs(-32768) has no 16-bit positive form, so it clips to 32767
    function automatic logic [15:0] sat_abs(input logic [15:0] v);
        if (v == 16'h8000)
            return 16'h7FFF;
        else if (v[15])
            return ~v + 16'd1;
        else
            return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gyro_still_chk.sv
`default_nettype none
// ============================================================================
// Module      : gyro_still_chk
// Description : Combinational three-axis stillness test on a gyro sample.
// Revision    : 1.0 - initial release
// ============================================================================
module gyro_still_chk
    import drone_pkg::*;
#(
    parameter logic [15:0] THRESH = C_GYRO_THRESH
) (
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic        still
);

    assign still = (sat_abs(gyro_x) <= THRESH) &&
                   (sat_abs(gyro_y) <= THRESH) &&
                   (sat_abs(gyro_z) <= THRESH);

endmodule
`default_nettype wire

// File: rtl/drone_sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module      : drone_sensor_monitor
// Description : Gyro stability qualifier, RC link supervisor and flight latch.
//               Define DRONE_MON_HYST_EN to forgive a single non-still sample.
// Revision    : 1.0 - initial release
// ============================================================================
module drone_sensor_monitor #(
    parameter logic [15:0] GYRO_THRESH  = drone_pkg::C_GYRO_THRESH,
    parameter int          STABLE_CNT   = drone_pkg::C_STABLE_CNT,
    parameter int          LINK_ACQ     = drone_pkg::C_LINK_ACQ,
    parameter int          LINK_TIMEOUT = drone_pkg::C_LINK_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gyro_valid,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    input  logic        rx_frame,
    input  logic        rx_crc_err,
    input  logic        takeoff,
    input  logic        landing,
    output logic        gyrocheck,
    output logic        reciverenable,
    output logic        airborne,
    output logic        link_lost
);

    localparam int C_CNT_W = $clog2(STABLE_CNT + 1);
    localparam int C_ACQ_W = $clog2(LINK_ACQ + 1);
    localparam int C_TMR_W = $clog2(LINK_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STABLE_CNT);
    localparam logic [C_ACQ_W-1:0] C_ACQ_MAX = C_ACQ_W'(LINK_ACQ);
    localparam logic [C_TMR_W-1:0] C_TMR_MAX = C_TMR_W'(LINK_TIMEOUT);

    logic                  w_still;
    logic                  w_good;
    logic [C_TMR_W-1:0]    w_timer_inc;
    logic [C_CNT_W-1:0]    r_still_cnt;
    logic                  r_gyrocheck;
    logic                  r_airborne;
    drone_pkg::link_state_t r_state;
    logic [C_ACQ_W-1:0]    r_acq_cnt;
    logic [C_TMR_W-1:0]    r_timer;
    logic                  r_rxen;
    logic                  r_lost;
`ifdef DRONE_MON_HYST_EN
    logic                  r_bad_pend;
`endif

    gyro_still_chk #(
        .THRESH (GYRO_THRESH)
    ) u_still_chk (
        .gyro_x (gyro_x),
        .gyro_y (gyro_y),
        .gyro_z (gyro_z),
        .still  (w_still)
    );

    assign w_good      = rx_frame & ~rx_crc_err;
    assign w_timer_inc = (r_timer == C_TMR_MAX) ? r_timer : r_timer + 1'b1;

    // Stillness qualifier; frozen in flight so attitude motion cannot drop it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_still_cnt <= '0;
            r_gyrocheck <= 1'b0;
`ifdef DRONE_MON_HYST_EN
            r_bad_pend  <= 1'b0;
`endif
        end else if (gyro_valid && !r_airborne) begin
            if (w_still) begin
                if (r_still_cnt != C_CNT_MAX)
                    r_still_cnt <= r_still_cnt + 1'b1;
                if (r_still_cnt >= C_CNT_MAX - 1'b1)
                    r_gyrocheck <= 1'b1;
`ifdef DRONE_MON_HYST_EN
                r_bad_pend  <= 1'b0;
            end else if (!r_bad_pend) begin
                r_bad_pend  <= 1'b1;
            end else begin
                r_bad_pend  <= 1'b0;
                r_still_cnt <= '0;
                r_gyrocheck <= 1'b0;
`else
            end else begin
                r_still_cnt <= '0;
                r_gyrocheck <= 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_airborne <= 1'b0;
        else if (landing)
            r_airborne <= 1'b0;
        else if (takeoff)
            r_airborne <= 1'b1;
    end

    // Link supervisor; a good frame restarts the silence timer in ACQ and UP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= drone_pkg::LINK_DOWN;
            r_acq_cnt <= '0;
            r_timer   <= '0;
            r_rxen    <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_lost <= 1'b0;
            case (r_state)
                drone_pkg::LINK_DOWN: begin
                    r_timer <= '0;
                    if (w_good) begin
                        r_acq_cnt <= C_ACQ_W'(1);
                        if (LINK_ACQ <= 1) begin
                            r_state <= drone_pkg::LINK_UP;
                            r_rxen  <= 1'b1;
                        end else begin
                            r_state <= drone_pkg::LINK_ACQ;
                        end
                    end
                end
                drone_pkg::LINK_ACQ: begin
                    if (w_good) begin
                        r_timer   <= '0;
                        r_acq_cnt <= r_acq_cnt + 1'b1;
                        if (r_acq_cnt >= C_ACQ_MAX - 1'b1) begin
                            r_state <= drone_pkg::LINK_UP;
                            r_rxen  <= 1'b1;
                        end
                    end else if (w_timer_inc == C_TMR_MAX) begin
                        r_state   <= drone_pkg::LINK_DOWN;
                        r_acq_cnt <= '0;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                drone_pkg::LINK_UP: begin
                    if (w_good) begin
                        r_timer <= '0;
                    end else if (w_timer_inc == C_TMR_MAX) begin
                        r_state   <= drone_pkg::LINK_DOWN;
                        r_acq_cnt <= '0;
                        r_timer   <= '0;
                        r_rxen    <= 1'b0;
                        r_lost    <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state   <= drone_pkg::LINK_DOWN;
                    r_acq_cnt <= '0;
                    r_timer   <= '0;
                    r_rxen    <= 1'b0;
                end
            endcase
        end
    end

    assign gyrocheck     = r_gyrocheck;
    assign reciverenable = r_rxen;
    assign airborne      = r_airborne;
    assign link_lost     = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_drone_sensor_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_drone_sensor_monitor
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drone_sensor_monitor;

    localparam int STABLE  = 8;
    localparam int ACQ     = 3;
    localparam int TMO     = 1000;
    localparam int THRESH  = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        gyro_valid;
    logic [15:0] gyro_x, gyro_y, gyro_z;
    logic        rx_frame, rx_crc_err, takeoff, landing;
    logic        gyrocheck, reciverenable, airborne, link_lost;

    drone_sensor_monitor #(
        .GYRO_THRESH  (16'(THRESH)),
        .STABLE_CNT   (STABLE),
        .LINK_ACQ     (ACQ),
        .LINK_TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gyro_valid    (gyro_valid),
        .gyro_x        (gyro_x),
        .gyro_y        (gyro_y),
        .gyro_z        (gyro_z),
        .rx_frame      (rx_frame),
        .rx_crc_err    (rx_crc_err),
        .takeoff       (takeoff),
        .landing       (landing),
        .gyrocheck     (gyrocheck),
        .reciverenable (reciverenable),
        .airborne      (airborne),
        .link_lost     (link_lost)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: run length of still samples, frames since link loss
    int m_run;
    bit m_bad;
    bit m_air;
    int m_frames;
    int m_silence;
    bit m_lost;

    typedef struct {
        logic        gv;
        logic [15:0] x, y, z;
        logic        exp_gc;
    } gvec_t;

    gvec_t tbl[20];

    task automatic chk(input string name, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic int sabs(input logic [15:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    function automatic bit is_still(input logic [15:0] x, input logic [15:0] y,
                                    input logic [15:0] z);
        return sabs(x) <= THRESH && sabs(y) <= THRESH && sabs(z) <= THRESH;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_run = 0; m_bad = 0; m_air = 0;
            m_frames = 0; m_silence = 0; m_lost = 0;
        end else begin
            m_lost = 0;
            if (gyro_valid && !m_air) begin
                if (is_still(gyro_x, gyro_y, gyro_z)) begin
                    if (m_run < STABLE) m_run++;
                    m_bad = 0;
                end else begin
`ifdef DRONE_MON_HYST_EN
                    if (m_bad) begin m_run = 0; m_bad = 0; end
                    else m_bad = 1;
`else
                    m_run = 0;
`endif
                end
            end
            if (landing) m_air = 0;
            else if (takeoff) m_air = 1;
            if (rx_frame && !rx_crc_err) begin
                if (m_frames < ACQ) m_frames++;
                m_silence = 0;
            end else if (m_frames > 0) begin
                m_silence++;
                if (m_silence >= TMO) begin
                    m_lost    = (m_frames >= ACQ);
                    m_frames  = 0;
                    m_silence = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("model_gyrocheck", gyrocheck, m_run >= STABLE);
        chk("model_reciverenable", reciverenable, m_frames >= ACQ);
        chk("model_airborne", airborne, m_air);
        chk("model_link_lost", link_lost, m_lost);
    endtask

    task automatic clear_inputs();
        reset = 0; gyro_valid = 0; rx_frame = 0; rx_crc_err = 0;
        takeoff = 0; landing = 0; gyro_x = 0; gyro_y = 0; gyro_z = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send_frame(input bit good);
        rx_frame = 1; rx_crc_err = !good;
        step();
        rx_frame = 0; rx_crc_err = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic gyro_sample(input logic [15:0] x, input logic [15:0] y,
                               input logic [15:0] z);
        gyro_valid = 1; gyro_x = x; gyro_y = y; gyro_z = z;
        step();
        gyro_valid = 0;
    endtask

    initial begin
        int pulses;
        int period;
        int r;
        clear_inputs();
        m_run = 0; m_bad = 0; m_air = 0; m_frames = 0; m_silence = 0; m_lost = 0;

        for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 16'd10, 16'hFFF6, 16'd50, 1'b0};
        tbl[7]  = '{1'b1, 16'd10,   16'hFFF6, 16'd50,   1'b1};
        tbl[8]  = '{1'b0, 16'd5000, 16'd5000, 16'd5000, 1'b1};
        tbl[9]  = '{1'b1, 16'd200,  16'hFF38, 16'd200,  1'b1};
`ifdef DRONE_MON_HYST_EN
        tbl[10] = '{1'b1, 16'd0,    16'h8000, 16'd0,    1'b1};
`else
        tbl[10] = '{1'b1, 16'd0,    16'h8000, 16'd0,    1'b0};
`endif
        tbl[11] = '{1'b1, 16'd201,  16'd0,    16'd0,    1'b0};
        for (int i = 12; i < 19; i++) tbl[i] = '{1'b1, 16'hFF38, 16'd200, 16'hFF38, 1'b0};
        tbl[19] = '{1'b1, 16'd0,    16'd0,    16'd0,    1'b1};

        reset = 1;
        step();
        step();
        chk("rst_gyrocheck", gyrocheck, 1'b0);
        chk("rst_reciverenable", reciverenable, 1'b0);
        chk("rst_airborne", airborne, 1'b0);
        chk("rst_link_lost", link_lost, 1'b0);
        reset = 0;

        for (int i = 0; i < 20; i++) begin
            gyro_valid = tbl[i].gv;
            gyro_x = tbl[i].x; gyro_y = tbl[i].y; gyro_z = tbl[i].z;
            step();
            chk($sformatf("tbl_gc[%0d]", i), gyrocheck, tbl[i].exp_gc);
        end
        gyro_valid = 0;

        // Flight freezes the qualifier; simultaneous takeoff/landing clears airborne
        takeoff = 1; step(); takeoff = 0;
        chk("takeoff_air", airborne, 1'b1);
        for (int i = 0; i < 3; i++) begin
            gyro_sample(16'h8000, 16'h8000, 16'h8000);
            chk("air_gc_hold", gyrocheck, 1'b1);
        end
        landing = 1; step(); landing = 0;
        chk("landing_air", airborne, 1'b0);
        takeoff = 1; step();
        landing = 1; step(); takeoff = 0; landing = 0;
        chk("both_air", airborne, 1'b0);

        // Acquisition with frames 50 cycles apart
        do_reset();
        send_frame(1); idle(49);
        send_frame(1); idle(49);
        chk("acq_two", reciverenable, 1'b0);
        send_frame(1);
        chk("acq_three", reciverenable, 1'b1);

        do_reset();
        send_frame(1); idle(49);
        send_frame(1); idle(49);
        send_frame(0);
        chk("crc_no_adv", reciverenable, 1'b0);
        idle(49);
        chk("crc_still_down", reciverenable, 1'b0);
        send_frame(1);
        chk("crc_late_up", reciverenable, 1'b1);

        // Silence timeout: a frame after 999 idle cycles rescues the link
        idle(999);
        chk("tmo_999_up", reciverenable, 1'b1);
        send_frame(1);
        chk("tmo_rescued", reciverenable, 1'b1);
        pulses = 0;
        for (int i = 0; i < TMO; i++) begin
            step();
            if (link_lost) pulses++;
            if (i == TMO - 2) chk("tmo_before", reciverenable, 1'b1);
        end
        chk("tmo_down", reciverenable, 1'b0);
        chk("tmo_lost_at_edge", link_lost, 1'b1);
        idle(3);
        if (link_lost) pulses++;
        chk_int("tmo_pulses", pulses, 1);

        // Reset has priority mid-acquisition and mid-flight
        for (int i = 0; i < STABLE; i++) gyro_sample(16'd1, 16'd2, 16'd3);
        chk("pre_rst_gc", gyrocheck, 1'b1);
        send_frame(1);
        takeoff = 1; step(); takeoff = 0;
        chk("pre_rst_air", airborne, 1'b1);
        reset = 1; takeoff = 1; rx_frame = 1; gyro_valid = 1;
        gyro_x = 0; gyro_y = 0; gyro_z = 0;
        step();
        clear_inputs();
        chk("prio_gc", gyrocheck, 1'b0);
        chk("prio_rxen", reciverenable, 1'b0);
        chk("prio_air", airborne, 1'b0);
        chk("prio_lost", link_lost, 1'b0);
        send_frame(1); send_frame(1);
        chk("prio_relearn_two", reciverenable, 1'b0);
        send_frame(1);
        chk("prio_relearn_three", reciverenable, 1'b1);

        // Randomized traffic against the reference model
        period = 20;
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) begin
                r = int'($urandom_range(0, 3));
                period = (r == 0) ? 2 : (r == 1) ? 20 : (r == 2) ? 200 : 5000;
            end
            gyro_valid = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 15));
            gyro_x = (r == 0) ? 16'h8000 : (r == 1) ? 16'($urandom) :
                     16'($urandom_range(0, 420)) - 16'd210;
            gyro_y = 16'($urandom_range(0, 420)) - 16'd210;
            gyro_z = 16'($urandom_range(0, 420)) - 16'd210;
            rx_frame   = ($urandom_range(0, period - 1) == 0);
            rx_crc_err = ($urandom_range(0, 3) == 0);
            takeoff    = ($urandom_range(0, 99) == 0);
            landing    = ($urandom_range(0, 99) == 0);
            reset      = ($urandom_range(0, 699) == 0);
            step();
        end
        clear_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
